// File: rtl/io_axi_lite_bridge.sv
// io_axi_lite_bridge
// Round-robin arbiter over NUM_REQUESTERS cores feeding a request FIFO, a
// single-outstanding AXI4-Lite master, and a FWFT response FIFO. The response
// FIFO cannot overflow: a slot is reserved (credit) before a transaction starts.
//
// state          | meaning
// ---------------+-----------------------------------------------------------
// S_IDLE         | waiting for a queued request and a free response credit
// S_RD_ADDR      | arvalid high, waiting for arready
// S_RD_DATA      | rready high, waiting for rvalid
// S_WR_ADDR_DATA | awvalid/wvalid high until each channel's own handshake
// S_WR_RESP      | bready high, waiting for bvalid
module io_axi_lite_bridge #(
  parameter int NUM_REQUESTERS = 4,
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TAG_WIDTH      = 2,
  parameter int REQ_FIFO_DEPTH = 8,
  parameter int RSP_FIFO_DEPTH = 8,
  parameter int TIMEOUT_CYCLES = 1024,
  localparam int CORE_W = (NUM_REQUESTERS > 1) ? $clog2(NUM_REQUESTERS) : 1,
  localparam int STRB_W = DATA_WIDTH / 8
) (
  input  logic                                clk,
  input  logic                                reset_n,
  input  logic [NUM_REQUESTERS-1:0]           req_valid,
  output logic [NUM_REQUESTERS-1:0]           req_ready,
  input  logic [NUM_REQUESTERS-1:0]           req_store,
  input  logic [NUM_REQUESTERS*ADDR_WIDTH-1:0] req_addr,
  input  logic [NUM_REQUESTERS*DATA_WIDTH-1:0] req_wdata,
  input  logic [NUM_REQUESTERS*STRB_W-1:0]    req_wstrb,
  input  logic [NUM_REQUESTERS*TAG_WIDTH-1:0] req_tag,
  output logic                                rsp_valid,
  input  logic                                rsp_ready,
  output logic [CORE_W-1:0]                   rsp_core,
  output logic [TAG_WIDTH-1:0]                rsp_tag,
  output logic                                rsp_store,
  output logic [DATA_WIDTH-1:0]               rsp_rdata,
  output logic [1:0]                          rsp_error,
  output logic                                m_axi_awvalid,
  input  logic                                m_axi_awready,
  output logic [ADDR_WIDTH-1:0]               m_axi_awaddr,
  output logic [2:0]                          m_axi_awprot,
  output logic                                m_axi_wvalid,
  input  logic                                m_axi_wready,
  output logic [DATA_WIDTH-1:0]               m_axi_wdata,
  output logic [STRB_W-1:0]                   m_axi_wstrb,
  input  logic                                m_axi_bvalid,
  output logic                                m_axi_bready,
  input  logic [1:0]                          m_axi_bresp,
  output logic                                m_axi_arvalid,
  input  logic                                m_axi_arready,
  output logic [ADDR_WIDTH-1:0]               m_axi_araddr,
  output logic [2:0]                          m_axi_arprot,
  input  logic                                m_axi_rvalid,
  output logic                                m_axi_rready,
  input  logic [DATA_WIDTH-1:0]               m_axi_rdata,
  input  logic [1:0]                          m_axi_rresp
);

  localparam int RQ_AW  = $clog2(REQ_FIFO_DEPTH);
  localparam int RS_AW  = $clog2(RSP_FIFO_DEPTH);
  localparam int CRED_W = $clog2(RSP_FIFO_DEPTH + 1);
  localparam int TMR_W  = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

  typedef enum logic [2:0] {
    S_IDLE, S_RD_ADDR, S_RD_DATA, S_WR_ADDR_DATA, S_WR_RESP
  } state_t;

  function automatic logic [1:0] map_resp(input logic [1:0] resp);
    case (resp)
      2'b10:   return 2'd1;
      2'b11:   return 2'd2;
      default: return 2'd0;
    endcase
  endfunction

  // ---------------- arbiter ----------------
  logic [CORE_W-1:0] arb_ptr;
  logic [CORE_W-1:0] grant_idx;
  logic              grant_vld;
  logic [CORE_W:0]   cand;
  logic              ready_en;
  logic              req_accept;
  logic              rq_full, rq_empty;

  // Round-robin search starting at pointer+1; scanning lowest priority first
  // lets the highest-priority requester overwrite the result.
  always_comb begin
    grant_idx = '0;
    grant_vld = 1'b0;
    cand      = '0;
    for (int k = NUM_REQUESTERS; k >= 1; k--) begin
      cand = {1'b0, arb_ptr} + (CORE_W+1)'(k);
      if (cand >= (CORE_W+1)'(NUM_REQUESTERS)) cand = cand - (CORE_W+1)'(NUM_REQUESTERS);
      if (req_valid[cand[CORE_W-1:0]]) begin
        grant_idx = cand[CORE_W-1:0];
        grant_vld = 1'b1;
      end
    end
  end

  // One-hot accept; held off until the first clock after reset releases.
  always_comb begin
    req_ready = '0;
    if (ready_en && grant_vld && !rq_full) req_ready[grant_idx] = 1'b1;
  end
  assign req_accept = |req_ready;

  // Pointer only moves on an actual handshake.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      arb_ptr  <= '0;
      ready_en <= 1'b0;
    end else begin
      ready_en <= 1'b1;
      if (req_accept) arb_ptr <= grant_idx;
    end
  end

  // ---------------- request FIFO ----------------
  logic [CORE_W-1:0]     rq_core  [REQ_FIFO_DEPTH];
  logic [TAG_WIDTH-1:0]  rq_tag   [REQ_FIFO_DEPTH];
  logic                  rq_store [REQ_FIFO_DEPTH];
  logic [ADDR_WIDTH-1:0] rq_addr  [REQ_FIFO_DEPTH];
  logic [DATA_WIDTH-1:0] rq_wdata [REQ_FIFO_DEPTH];
  logic [STRB_W-1:0]     rq_wstrb [REQ_FIFO_DEPTH];
  logic [RQ_AW:0]        rq_wptr, rq_rptr;
  logic                  rq_pop;

  assign rq_empty = (rq_wptr == rq_rptr);
  assign rq_full  = (rq_wptr[RQ_AW] != rq_rptr[RQ_AW]) &&
                    (rq_wptr[RQ_AW-1:0] == rq_rptr[RQ_AW-1:0]);

  // Request storage; written on the accept edge.
  always_ff @(posedge clk) begin
    if (req_accept) begin
      rq_core [rq_wptr[RQ_AW-1:0]] <= grant_idx;
      rq_tag  [rq_wptr[RQ_AW-1:0]] <= req_tag  [grant_idx*TAG_WIDTH  +: TAG_WIDTH];
      rq_store[rq_wptr[RQ_AW-1:0]] <= req_store[grant_idx];
      rq_addr [rq_wptr[RQ_AW-1:0]] <= req_addr [grant_idx*ADDR_WIDTH +: ADDR_WIDTH];
      rq_wdata[rq_wptr[RQ_AW-1:0]] <= req_wdata[grant_idx*DATA_WIDTH +: DATA_WIDTH];
      rq_wstrb[rq_wptr[RQ_AW-1:0]] <= req_wstrb[grant_idx*STRB_W     +: STRB_W];
    end
  end

  // Request FIFO pointers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rq_wptr <= '0;
      rq_rptr <= '0;
    end else begin
      if (req_accept) rq_wptr <= rq_wptr + 1'b1;
      if (rq_pop)     rq_rptr <= rq_rptr + 1'b1;
    end
  end

  logic [CORE_W-1:0]    hd_core;
  logic [TAG_WIDTH-1:0] hd_tag;
  logic                 hd_store;
  assign hd_core  = rq_core [rq_rptr[RQ_AW-1:0]];
  assign hd_tag   = rq_tag  [rq_rptr[RQ_AW-1:0]];
  assign hd_store = rq_store[rq_rptr[RQ_AW-1:0]];

  // ---------------- transaction FSM ----------------
  state_t             state, state_nxt;
  logic               aw_done, w_done, aw_done_nxt, w_done_nxt;
  logic               aw_now, w_now;
  logic [TMR_W-1:0]   tmr;
  logic               timed_out;
  logic [CRED_W-1:0]  credit;
  logic               credit_take;
  logic               rs_push, rs_pop;
  logic [1:0]         rs_push_err;
  logic [DATA_WIDTH-1:0] rs_push_data;

  assign timed_out = (TIMEOUT_CYCLES > 0) && (tmr == TMR_LAST);

  // Next state; a handshake in the final timer cycle wins over the timeout.
  always_comb begin
    state_nxt    = state;
    aw_done_nxt  = aw_done;
    w_done_nxt   = w_done;
    aw_now       = 1'b0;
    w_now        = 1'b0;
    rq_pop       = 1'b0;
    rs_push      = 1'b0;
    rs_push_err  = 2'd0;
    rs_push_data = '0;
    credit_take  = 1'b0;
    case (state)
      S_IDLE: begin
        if (!rq_empty && credit != '0) begin
          credit_take = 1'b1;
          aw_done_nxt = 1'b0;
          w_done_nxt  = 1'b0;
          state_nxt   = hd_store ? S_WR_ADDR_DATA : S_RD_ADDR;
        end
      end
      S_RD_ADDR: begin
        if (m_axi_arready) state_nxt = S_RD_DATA;
        else if (timed_out) begin
          rs_push = 1'b1; rs_push_err = 2'd3; rs_push_data = '1; rq_pop = 1'b1;
          state_nxt = S_IDLE;
        end
      end
      S_RD_DATA: begin
        if (m_axi_rvalid) begin
          rs_push = 1'b1; rs_push_err = map_resp(m_axi_rresp); rs_push_data = m_axi_rdata;
          rq_pop = 1'b1;
          state_nxt = S_IDLE;
        end else if (timed_out) begin
          rs_push = 1'b1; rs_push_err = 2'd3; rs_push_data = '1; rq_pop = 1'b1;
          state_nxt = S_IDLE;
        end
      end
      S_WR_ADDR_DATA: begin
        aw_now = aw_done | m_axi_awready;
        w_now  = w_done  | m_axi_wready;
        if (aw_now && w_now) state_nxt = S_WR_RESP;
        else if (timed_out) begin
          rs_push = 1'b1; rs_push_err = 2'd3; rs_push_data = '1; rq_pop = 1'b1;
          state_nxt = S_IDLE;
        end else begin
          aw_done_nxt = aw_now;
          w_done_nxt  = w_now;
        end
      end
      S_WR_RESP: begin
        if (m_axi_bvalid) begin
          rs_push = 1'b1; rs_push_err = map_resp(m_axi_bresp); rq_pop = 1'b1;
          state_nxt = S_IDLE;
        end else if (timed_out) begin
          rs_push = 1'b1; rs_push_err = 2'd3; rs_push_data = '1; rq_pop = 1'b1;
          state_nxt = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // State, per-channel write handshake flags and the per-state timer.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= S_IDLE;
      aw_done <= 1'b0;
      w_done  <= 1'b0;
      tmr     <= '0;
    end else begin
      state   <= state_nxt;
      aw_done <= aw_done_nxt;
      w_done  <= w_done_nxt;
      if (state_nxt != state)  tmr <= '0;
      else if (state != S_IDLE) tmr <= tmr + TMR_W'(1);
    end
  end

  assign m_axi_arvalid = (state == S_RD_ADDR);
  assign m_axi_rready  = (state == S_RD_DATA);
  assign m_axi_awvalid = (state == S_WR_ADDR_DATA) && !aw_done;
  assign m_axi_wvalid  = (state == S_WR_ADDR_DATA) && !w_done;
  assign m_axi_bready  = (state == S_WR_RESP);
  assign m_axi_araddr  = rq_addr [rq_rptr[RQ_AW-1:0]];
  assign m_axi_awaddr  = rq_addr [rq_rptr[RQ_AW-1:0]];
  assign m_axi_wdata   = rq_wdata[rq_rptr[RQ_AW-1:0]];
  assign m_axi_wstrb   = rq_wstrb[rq_rptr[RQ_AW-1:0]];
  assign m_axi_awprot  = 3'b000;
  assign m_axi_arprot  = 3'b000;

  // Response-slot credits: taken when a transaction starts, returned on pop.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) credit <= CRED_W'(RSP_FIFO_DEPTH);
    else begin
      case ({credit_take, rs_pop})
        2'b10:   credit <= credit - 1'b1;
        2'b01:   credit <= credit + 1'b1;
        default: credit <= credit;
      endcase
    end
  end

  // ---------------- response FIFO ----------------
  logic [CORE_W-1:0]     rs_core  [RSP_FIFO_DEPTH];
  logic [TAG_WIDTH-1:0]  rs_tag   [RSP_FIFO_DEPTH];
  logic                  rs_store [RSP_FIFO_DEPTH];
  logic [DATA_WIDTH-1:0] rs_rdata [RSP_FIFO_DEPTH];
  logic [1:0]            rs_err   [RSP_FIFO_DEPTH];
  logic [RS_AW:0]        rs_wptr, rs_rptr;

  assign rsp_valid = (rs_wptr != rs_rptr);
  assign rs_pop    = rsp_valid && rsp_ready;
  assign rsp_core  = rs_core [rs_rptr[RS_AW-1:0]];
  assign rsp_tag   = rs_tag  [rs_rptr[RS_AW-1:0]];
  assign rsp_store = rs_store[rs_rptr[RS_AW-1:0]];
  assign rsp_rdata = rs_rdata[rs_rptr[RS_AW-1:0]];
  assign rsp_error = rs_err  [rs_rptr[RS_AW-1:0]];

  // Response storage; tagged with the head request's origin.
  always_ff @(posedge clk) begin
    if (rs_push) begin
      rs_core [rs_wptr[RS_AW-1:0]] <= hd_core;
      rs_tag  [rs_wptr[RS_AW-1:0]] <= hd_tag;
      rs_store[rs_wptr[RS_AW-1:0]] <= hd_store;
      rs_rdata[rs_wptr[RS_AW-1:0]] <= rs_push_data;
      rs_err  [rs_wptr[RS_AW-1:0]] <= rs_push_err;
    end
  end

  // Response FIFO pointers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rs_wptr <= '0;
      rs_rptr <= '0;
    end else begin
      if (rs_push) rs_wptr <= rs_wptr + 1'b1;
      if (rs_pop)  rs_rptr <= rs_rptr + 1'b1;
    end
  end

endmodule

// File: tb/tb_io_axi_lite_bridge.sv
// Directed bench for io_axi_lite_bridge with a small behavioural AXI4-Lite slave.
module tb_io_axi_lite_bridge;

  localparam int N  = 4;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TW = 2;
  localparam int SW = 4;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic [N-1:0]    req_valid = '0, req_store = '0;
  logic [N-1:0]    req_ready;
  logic [N*AW-1:0] req_addr = '0;
  logic [N*DW-1:0] req_wdata = '0;
  logic [N*SW-1:0] req_wstrb = '0;
  logic [N*TW-1:0] req_tag = '0;
  logic            rsp_valid;
  logic            rsp_ready = 1'b0;
  logic [1:0]      rsp_core, rsp_tag, rsp_error;
  logic            rsp_store;
  logic [DW-1:0]   rsp_rdata;
  logic            m_axi_awvalid, m_axi_wvalid, m_axi_bready, m_axi_arvalid, m_axi_rready;
  logic            m_axi_awready = 1'b0, m_axi_wready = 1'b0, m_axi_bvalid = 1'b0;
  logic            m_axi_arready = 1'b0, m_axi_rvalid = 1'b0;
  logic [AW-1:0]   m_axi_awaddr, m_axi_araddr;
  logic [2:0]      m_axi_awprot, m_axi_arprot;
  logic [DW-1:0]   m_axi_wdata;
  logic [SW-1:0]   m_axi_wstrb;
  logic [1:0]      m_axi_bresp = 2'b00, m_axi_rresp = 2'b00;
  logic [DW-1:0]   m_axi_rdata = '0;

  io_axi_lite_bridge #(.NUM_REQUESTERS(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TAG_WIDTH(TW),
                       .REQ_FIFO_DEPTH(8), .RSP_FIFO_DEPTH(8), .TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_store(req_store), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_wstrb(req_wstrb), .req_tag(req_tag),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_core(rsp_core), .rsp_tag(rsp_tag),
    .rsp_store(rsp_store), .rsp_rdata(rsp_rdata), .rsp_error(rsp_error),
    .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready), .m_axi_awaddr(m_axi_awaddr),
    .m_axi_awprot(m_axi_awprot), .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready),
    .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb), .m_axi_bvalid(m_axi_bvalid),
    .m_axi_bready(m_axi_bready), .m_axi_bresp(m_axi_bresp), .m_axi_arvalid(m_axi_arvalid),
    .m_axi_arready(m_axi_arready), .m_axi_araddr(m_axi_araddr), .m_axi_arprot(m_axi_arprot),
    .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready), .m_axi_rdata(m_axi_rdata),
    .m_axi_rresp(m_axi_rresp)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  core;
    logic [1:0]  tag;
    logic        store;
    logic [31:0] rdata;
    logic [1:0]  err;
  } rsp_t;

  rsp_t        rsp_log[$];
  logic [31:0] ar_log[$], aw_log[$], w_log[$], r_q[$];
  logic [3:0]  ws_log[$];
  int ar_hs = 0, aw_hs = 0, w_hs = 0, b_hs = 0, aw_age = 0, w_age = 0;

  bit          ar_en = 1, b_en = 1, rsp_en = 1, rd_fix = 0;
  logic [31:0] rdata_fix = '0;
  logic [1:0]  rresp_q = 2'b00, bresp_q = 2'b00;
  int          aw_delay = 0, w_delay = 0;

  int n_chk = 0;
  int n_err = 0;

  // Slave and response sink: drive on the falling edge, record handshakes
  // that the next rising edge will complete.
  always @(negedge clk) begin
    m_axi_arready = ar_en && m_axi_arvalid;
    m_axi_rvalid  = (r_q.size() > 0);
    m_axi_rdata   = rd_fix ? rdata_fix : ((r_q.size() > 0) ? {16'hD000, r_q[0][15:0]} : 32'h0);
    m_axi_rresp   = rresp_q;
    if (m_axi_rvalid && m_axi_rready) void'(r_q.pop_front());
    if (m_axi_arvalid && m_axi_arready) begin
      ar_hs++;
      ar_log.push_back(m_axi_araddr);
      r_q.push_back(m_axi_araddr);
    end
    m_axi_awready = m_axi_awvalid && (aw_age >= aw_delay);
    m_axi_wready  = m_axi_wvalid && (w_age >= w_delay);
    m_axi_bvalid  = b_en && (((aw_hs < w_hs) ? aw_hs : w_hs) > b_hs);
    m_axi_bresp   = bresp_q;
    if (m_axi_bvalid && m_axi_bready) b_hs++;
    if (m_axi_awvalid) begin
      if (m_axi_awready) begin aw_hs++; aw_log.push_back(m_axi_awaddr); aw_age = 0; end
      else aw_age++;
    end
    if (m_axi_wvalid) begin
      if (m_axi_wready) begin w_hs++; w_log.push_back(m_axi_wdata); ws_log.push_back(m_axi_wstrb); w_age = 0; end
      else w_age++;
    end
    rsp_ready = rsp_en;
    if (rsp_valid && rsp_ready)
      rsp_log.push_back('{core: rsp_core, tag: rsp_tag, store: rsp_store, rdata: rsp_rdata, err: rsp_error});
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] mk(input logic [1:0] c, input logic [1:0] t, input logic s,
                                     input logic [31:0] d, input logic [1:0] e);
    return {25'b0, c, t, s, d, e};
  endfunction

  function automatic logic [63:0] pk(input rsp_t r);
    return mk(r.core, r.tag, r.store, r.rdata, r.err);
  endfunction

  task automatic do_reset();
    req_valid = '0;
    @(negedge clk);
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic issue(input int c, input logic st, input logic [31:0] a, input logic [31:0] d,
                       input logic [3:0] s, input logic [1:0] t);
    int guard;
    @(negedge clk);
    req_valid = '0;
    req_valid[c] = 1'b1;
    req_store[c] = st;
    req_addr[c*AW +: AW]  = a;
    req_wdata[c*DW +: DW] = d;
    req_wstrb[c*SW +: SW] = s;
    req_tag[c*TW +: TW]   = t;
    #1;
    guard = 0;
    while (!req_ready[c] && guard < 200) begin
      @(negedge clk); #1; guard++;
    end
    chk("accept", {63'b0, req_ready[c]}, 64'd1);
    @(negedge clk);
    req_valid[c] = 1'b0;
  endtask

  task automatic wait_rsp(input int n, input int budget, input string tag);
    int cyc;
    cyc = 0;
    while (rsp_log.size() < n && cyc < budget) begin
      @(negedge clk); cyc++;
    end
    chk(tag, rsp_log.size(), n);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int base_r, base_ar, base_aw, base_b, n_acc, guard, cnt;
    int acc_order[8];
    logic [5:0] aw_pat, w_pat;

    // reset state
    req_valid = '1;
    #12;
    chk("rst_req_ready", req_ready, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_axi_valids", {m_axi_arvalid, m_axi_awvalid, m_axi_wvalid, m_axi_rready, m_axi_bready}, 0);
    do_reset();

    // 1: single read from core 2
    base_r = rsp_log.size(); base_ar = ar_log.size();
    rd_fix = 1; rdata_fix = 32'hCAFEF00D;
    issue(2, 1'b0, 32'h100, 32'h0, 4'h0, 2'd1);
    wait_rsp(base_r + 1, 50, "t1_count");
    if (rsp_log.size() > base_r) chk("t1_rsp", pk(rsp_log[base_r]), mk(2'd2, 2'd1, 1'b0, 32'hCAFEF00D, 2'd0));
    if (ar_log.size() > base_ar) chk("t1_araddr", ar_log[base_ar], 32'h100);
    rd_fix = 0;

    // 2: all four cores writing continuously
    do_reset();
    base_r = rsp_log.size(); base_aw = aw_log.size();
    for (int c = 0; c < N; c++) begin
      req_store[c] = 1'b1;
      req_addr[c*AW +: AW]  = 32'h1000 + 32'(c * 16);
      req_wdata[c*DW +: DW] = 32'hA000_0000 + 32'(c);
      req_wstrb[c*SW +: SW] = 4'b0001 << c;
      req_tag[c*TW +: TW]   = 2'(c);
    end
    req_valid = '1;
    n_acc = 0; guard = 0;
    while (n_acc < 8 && guard < 100) begin
      #1;
      if (req_ready != '0) begin
        chk("t2_onehot", $countones(req_ready), 1);
        for (int c = 0; c < N; c++) if (req_ready[c]) acc_order[n_acc] = c;
        n_acc++;
      end
      @(negedge clk);
      guard++;
    end
    req_valid = '0;
    chk("t2_accepts", n_acc, 8);
    for (int i = 0; i < n_acc; i++) chk("t2_order", acc_order[i], (i + 1) % 4);
    wait_rsp(base_r + 8, 100, "t2_count");
    for (int i = 0; i < 8 && base_r + i < rsp_log.size(); i++)
      chk("t2_rsp", pk(rsp_log[base_r + i]), mk(2'((i + 1) % 4), 2'((i + 1) % 4), 1'b1, 32'h0, 2'd0));
    for (int i = 0; i < 8 && base_aw + i < aw_log.size(); i++) begin
      chk("t2_awaddr", aw_log[base_aw + i], 32'h1000 + 32'(((i + 1) % 4) * 16));
      chk("t2_wdata", w_log[base_aw + i], 32'hA000_0000 + 32'((i + 1) % 4));
      chk("t2_wstrb", ws_log[base_aw + i], 4'b0001 << ((i + 1) % 4));
    end

    // 3: W handshake three cycles before AW
    do_reset();
    base_r = rsp_log.size(); base_aw = aw_log.size(); base_b = b_hs;
    aw_delay = 3; w_delay = 0;
    issue(0, 1'b1, 32'h200, 32'h1234_5678, 4'hF, 2'd3);
    for (int k = 0; k < 6; k++) begin
      @(negedge clk); #1;
      aw_pat[k] = m_axi_awvalid;
      w_pat[k]  = m_axi_wvalid;
    end
    chk("t3_awvalid_seq", aw_pat, 6'b001111);
    chk("t3_wvalid_seq", w_pat, 6'b000001);
    wait_rsp(base_r + 1, 50, "t3_count");
    repeat (5) @(negedge clk);
    chk("t3_b_count", b_hs - base_b, 1);
    if (rsp_log.size() > base_r) chk("t3_rsp", pk(rsp_log[base_r]), mk(2'd0, 2'd3, 1'b1, 32'h0, 2'd0));
    if (aw_log.size() > base_aw) chk("t3_awaddr", aw_log[base_aw], 32'h200);
    aw_delay = 0;

    // 4: response backpressure limits issue to the credit count
    do_reset();
    base_r = rsp_log.size(); base_ar = ar_log.size();
    rsp_en = 0;
    for (int i = 0; i < 10; i++) issue(1, 1'b0, 32'h300 + 32'(4 * i), 32'h0, 4'h0, 2'(i));
    repeat (30) @(negedge clk);
    chk("t4_ar_stall", ar_log.size() - base_ar, 8);
    chk("t4_no_pop", rsp_log.size() - base_r, 0);
    chk("t4_rsp_valid", rsp_valid, 1);
    chk("t4_arvalid_idle", m_axi_arvalid, 0);
    rsp_en = 1;
    wait_rsp(base_r + 10, 200, "t4_count");
    chk("t4_ar_total", ar_log.size() - base_ar, 10);
    for (int i = 0; i < 10 && base_r + i < rsp_log.size(); i++)
      chk("t4_rsp", pk(rsp_log[base_r + i]), mk(2'd1, 2'(i), 1'b0, 32'hD000_0300 + 32'(4 * i), 2'd0));

    // 5: timeout on AR, then normal recovery
    do_reset();
    base_r = rsp_log.size();
    ar_en = 0;
    issue(3, 1'b0, 32'h400, 32'h0, 4'h0, 2'd2);
    cnt = 0; guard = 0;
    while (guard < 60) begin
      @(negedge clk); #1;
      guard++;
      if (m_axi_arvalid) cnt++;
      else if (cnt > 0) break;
    end
    chk("t5_arvalid_len", cnt, 16);
    wait_rsp(base_r + 1, 50, "t5_count");
    if (rsp_log.size() > base_r) chk("t5_rsp", pk(rsp_log[base_r]), mk(2'd3, 2'd2, 1'b0, 32'hFFFF_FFFF, 2'd3));
    ar_en = 1;
    issue(0, 1'b0, 32'h404, 32'h0, 4'h0, 2'd0);
    wait_rsp(base_r + 2, 50, "t5_count2");
    if (rsp_log.size() > base_r + 1) chk("t5_rsp2", pk(rsp_log[base_r + 1]), mk(2'd0, 2'd0, 1'b0, 32'hD000_0404, 2'd0));

    // 6a: error mapping
    do_reset();
    base_r = rsp_log.size();
    rresp_q = 2'b11;
    issue(1, 1'b0, 32'h500, 32'h0, 4'h0, 2'd0);
    wait_rsp(base_r + 1, 50, "t6_count_decerr");
    rresp_q = 2'b01;
    issue(1, 1'b0, 32'h504, 32'h0, 4'h0, 2'd1);
    wait_rsp(base_r + 2, 50, "t6_count_exokay");
    rresp_q = 2'b00;
    bresp_q = 2'b10;
    issue(2, 1'b1, 32'h508, 32'h55, 4'h1, 2'd2);
    wait_rsp(base_r + 3, 50, "t6_count_slverr");
    bresp_q = 2'b00;
    if (rsp_log.size() > base_r + 2) begin
      chk("t6_rresp11", pk(rsp_log[base_r]), mk(2'd1, 2'd0, 1'b0, 32'hD000_0500, 2'd2));
      chk("t6_rresp01", pk(rsp_log[base_r + 1]), mk(2'd1, 2'd1, 1'b0, 32'hD000_0504, 2'd0));
      chk("t6_bresp10", pk(rsp_log[base_r + 2]), mk(2'd2, 2'd2, 1'b1, 32'h0, 2'd1));
    end

    // 6b: reset during WR_RESP abandons the transaction
    do_reset();
    base_r = rsp_log.size();
    b_en = 0;
    issue(2, 1'b1, 32'h600, 32'h66, 4'hF, 2'd1);
    guard = 0;
    while (!m_axi_bready && guard < 20) begin @(negedge clk); #1; guard++; end
    chk("t6_in_wr_resp", m_axi_bready, 1);
    #2;
    reset_n = 1'b0;
    #1;
    chk("t6_rst_axi", {m_axi_arvalid, m_axi_awvalid, m_axi_wvalid, m_axi_rready, m_axi_bready}, 0);
    chk("t6_rst_rsp_valid", rsp_valid, 0);
    req_valid = '1;
    #1;
    chk("t6_rst_req_ready", req_ready, 0);
    req_valid = '0;
    @(negedge clk);
    reset_n = 1'b1;
    repeat (20) @(negedge clk);
    chk("t6_no_rsp", rsp_log.size() - base_r, 0);
    chk("t6_idle_after", {m_axi_awvalid, m_axi_bready, rsp_valid}, 0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
